// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic bit width_ok(input int w);
        return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/countdown_timer_decr4.sv
// Combinational 4-bit decrementor (out = in - 1 mod 16) in sum-of-products form.
module Decr4 (
    input  logic [3:0] i_in,
    output logic [3:0] o_out
);

    // Bit k toggles only when every lower bit is zero.
    assign o_out[0] = ~i_in[0];
    assign o_out[1] = (i_in[1] & i_in[0]) | (~i_in[1] & ~i_in[0]);
    assign o_out[2] = (i_in[2] & i_in[1]) | (i_in[2] & i_in[0])
                    | (~i_in[2] & ~i_in[1] & ~i_in[0]);
    assign o_out[3] = (i_in[3] & i_in[2]) | (i_in[3] & i_in[1]) | (i_in[3] & i_in[0])
                    | (~i_in[3] & ~i_in[2] & ~i_in[1] & ~i_in[0]);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with expiry pulse, sticky irq and optional auto-reload.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    input  logic             enable,
    input  logic             abort,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire,
    output logic             irq
);

    localparam int NIB = WIDTH / NIBBLE_W;

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("countdown_timer: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, r_reload, w_count_dec, w_count_nxt;
    logic [NIB:0]     w_low_zero;
    logic             r_expire, r_irq, w_accept, w_step;

    // Nibble i decrements only when all nibbles below it are zero (borrow chain).
    assign w_low_zero[0] = 1'b1;
    generate
        for (genvar i = 0; i < NIB; i++) begin : g_nib
            logic [NIBBLE_W-1:0] w_nib_dec;
            Decr4 u_decr4 (
                .i_in  (r_count[i*NIBBLE_W +: NIBBLE_W]),
                .o_out (w_nib_dec)
            );
            assign w_low_zero[i+1] = w_low_zero[i] & (r_count[i*NIBBLE_W +: NIBBLE_W] == '0);
            assign w_count_dec[i*NIBBLE_W +: NIBBLE_W] =
                w_low_zero[i] ? w_nib_dec : r_count[i*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    assign w_accept = load_valid & load_ready;
    assign w_step   = tick & enable & ~abort;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_accept) w_state_nxt = (load_value == '0) ? EXPIRE : RUN;
            RUN: begin
                if (abort)                               w_state_nxt = IDLE;
                else if (w_step && r_count == WIDTH'(1)) w_state_nxt = EXPIRE;
            end
            EXPIRE: begin
                // A zero reload value would otherwise spin here forever; abort is the exit.
                if (AUTO_RELOAD && r_reload == '0) w_state_nxt = abort ? IDLE : EXPIRE;
                else                               w_state_nxt = AUTO_RELOAD ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (r_state == IDLE) && !rst;
        busy       = (r_state != IDLE);
    end

    always_comb begin
        w_count_nxt = r_count;
        case (r_state)
            IDLE:    if (w_accept) w_count_nxt = load_value;
            RUN:     if (w_step)   w_count_nxt = w_count_dec;
            EXPIRE:  if (AUTO_RELOAD) w_count_nxt = r_reload;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_reload <= '0;
            r_expire <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            if (w_accept) r_reload <= load_value;
            r_expire <= (r_state == EXPIRE);
            r_irq    <= r_expire | (r_irq & ~irq_clr);
        end
    end

    assign count  = r_count;
    assign expire = r_expire;
    assign irq    = r_irq;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (one-shot and auto-reload) and the Decr4 nibble.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst;
    // one-shot instance
    logic        a_lv, a_lr, a_tick, a_en, a_abort, a_clr, a_busy, a_exp, a_irq;
    logic [15:0] a_val, a_cnt;
    // auto-reload instance
    logic        b_lv, b_lr, b_tick, b_en, b_abort, b_clr, b_busy, b_exp, b_irq;
    logic [15:0] b_val, b_cnt;
    logic [3:0]  d_in, d_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(16), .AUTO_RELOAD(1'b0)) u_dut (
        .clk(clk), .rst(rst), .load_valid(a_lv), .load_ready(a_lr), .load_value(a_val),
        .tick(a_tick), .enable(a_en), .abort(a_abort), .irq_clr(a_clr),
        .count(a_cnt), .busy(a_busy), .expire(a_exp), .irq(a_irq)
    );

    countdown_timer #(.WIDTH(16), .AUTO_RELOAD(1'b1)) u_dut_ar (
        .clk(clk), .rst(rst), .load_valid(b_lv), .load_ready(b_lr), .load_value(b_val),
        .tick(b_tick), .enable(b_en), .abort(b_abort), .irq_clr(b_clr),
        .count(b_cnt), .busy(b_busy), .expire(b_exp), .irq(b_irq)
    );

    Decr4 u_decr4 (.i_in(d_in), .o_out(d_out));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_lv = 0; a_val = '0; a_tick = 1; a_en = 1; a_abort = 0; a_clr = 0;
        b_lv = 0; b_val = '0; b_tick = 1; b_en = 1; b_abort = 0; b_clr = 0;
        d_in = '0;
        step(); step();
        chk("rst_count", a_cnt, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_lr, 0);
        chk("rst_expire", a_exp, 0);
        chk("rst_irq", a_irq, 0);
        rst = 1'b0;
        #1;
        chk("ready_idle", a_lr, 1);

        // Load 5 with continuous ticks
        a_lv = 1; a_val = 16'd5;
        step();
        a_lv = 0;
        chk("t1_load_cnt", a_cnt, 5);
        chk("t1_load_busy", a_busy, 1);
        chk("t1_load_ready", a_lr, 0);
        for (int k = 4; k >= 0; k--) begin
            step();
            chk("t1_cnt", a_cnt, 32'(k));
            chk("t1_noexp", a_exp, 0);
        end
        step();
        chk("t1_expire", a_exp, 1);
        chk("t1_idle", a_busy, 0);
        chk("t1_cnt0", a_cnt, 0);
        step();
        chk("t1_exp_pulse", a_exp, 0);
        chk("t1_irq", a_irq, 1);
        a_clr = 1;
        step();
        a_clr = 0;
        chk("t1_irq_clr", a_irq, 0);

        // Borrow chain across nibbles
        a_tick = 0; a_lv = 1; a_val = 16'h0100;
        step();
        a_lv = 0; a_tick = 1;
        step();
        chk("t2_0100", a_cnt, 16'h00FF);
        a_tick = 0; a_abort = 1;
        step();
        a_abort = 0;
        chk("t2_abort_idle", a_busy, 0);
        a_lv = 1; a_val = 16'h1000;
        step();
        a_lv = 0; a_tick = 1;
        step();
        chk("t2_1000", a_cnt, 16'h0FFF);
        a_tick = 0; a_abort = 1;
        step();
        a_abort = 0;
        chk("t2_abort_exp", a_exp, 0);

        // Zero-length timeout, irq set wins over clear
        a_lv = 1; a_val = 16'd0;
        step();
        a_lv = 0;
        chk("t3_zero_busy", a_busy, 1);
        chk("t3_zero_noexp", a_exp, 0);
        step();
        chk("t3_zero_exp", a_exp, 1);
        chk("t3_zero_cnt", a_cnt, 0);
        chk("t3_zero_idle", a_busy, 0);
        a_clr = 1;
        step();
        a_clr = 0;
        chk("t6_set_wins", a_irq, 1);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] e;
            e = 4'(i + 15);
            d_in = 4'(i);
            #1;
            chk("decr4", d_out, e);
        end

        // Abort after 4 ticks; load in RUN ignored
        a_tick = 0; a_lv = 1; a_val = 16'd10;
        step();
        a_lv = 0; a_tick = 1;
        for (int k = 0; k < 4; k++) step();
        chk("t5_cnt6", a_cnt, 6);
        a_tick = 0; a_lv = 1; a_val = 16'd3;
        #1;
        chk("t5_ready_run", a_lr, 0);
        step();
        chk("t5_no_accept", a_cnt, 6);
        chk("t5_still_run", a_busy, 1);
        a_lv = 0; a_tick = 1; a_abort = 1;
        step();
        a_abort = 0; a_tick = 0;
        chk("t5_abort_idle", a_busy, 0);
        chk("t5_abort_cnt", a_cnt, 6);
        chk("t5_abort_noexp", a_exp, 0);
        step();
        chk("t5_abort_noexp2", a_exp, 0);

        // Reset mid-run clears everything, irq still set from earlier
        a_tick = 1; a_lv = 1; a_val = 16'd5;
        step();
        a_lv = 0;
        step(); step();
        chk("t6_cnt3", a_cnt, 3);
        chk("t6_irq_before", a_irq, 1);
        rst = 1;
        step();
        chk("t6_rst_cnt", a_cnt, 0);
        chk("t6_rst_busy", a_busy, 0);
        chk("t6_rst_irq", a_irq, 0);
        chk("t6_rst_exp", a_exp, 0);
        rst = 0;

        // Auto-reload: load 3, period 4
        b_lv = 1; b_val = 16'd3;
        step();
        b_lv = 0;
        chk("t4_load", b_cnt, 3);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t4_exp", b_exp, ((k % 4) == 0) ? 1 : 0);
            if ((k % 4) == 0) chk("t4_reload", b_cnt, 3);
        end
        for (int k = 13; k <= 18; k++) begin
            b_en = (k > 14);
            step();
            chk("t4_stretch", b_exp, (k == 18) ? 1 : 0);
        end
        chk("t4_stretch_cnt", b_cnt, 3);
        b_abort = 1;
        step();
        b_abort = 0;
        chk("t4_abort", b_busy, 0);

        // Auto-reload with zero: pulses every cycle until abort
        b_lv = 1; b_val = 16'd0;
        step();
        b_lv = 0;
        step();
        chk("t4_z_exp1", b_exp, 1);
        step();
        chk("t4_z_exp2", b_exp, 1);
        chk("t4_z_busy", b_busy, 1);
        b_abort = 1;
        step();
        b_abort = 0;
        chk("t4_z_idle", b_busy, 0);
        step();
        chk("t4_z_stop", b_exp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
